// File: rtl/fact_pkg.sv
// Shared definitions for the factorial datapath: sequencer state encoding
// and the default operand width / largest n that still fits the product.
package fact_pkg;

  typedef enum logic {IDLE, RUN} seq_state_t;

  // 12! = 479001600 is the largest factorial that fits in 32 bits.
  localparam int FACT_WIDTH = 32;
  localparam int FACT_MAX_N = 12;

endpackage

// File: rtl/operand_dec_reg.sv
// Loadable down-counting operand register. A load takes priority over a
// decrement; q_is_one flags the final operand of a factorial sequence.
module operand_dec_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             q_is_one
);

  // Operand register: reset clears, load seeds n, dec steps toward 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= q - WIDTH'(1);
    end
  end

  assign q_is_one = (q == WIDTH'(1));

endmodule

// File: rtl/fact_operand_seq.sv
// Factorial operand sequencer: accepts n over a start handshake and streams
// n, n-1, ..., 1 to the multiplier with a last flag on the final operand.
// Out-of-range requests are rejected with a one-cycle err pulse; 0! and 1!
// both produce a single operand of 1.
module fact_operand_seq
  import fact_pkg::*;
#(
  parameter int WIDTH = FACT_WIDTH,
  parameter int MAX_N = FACT_MAX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_n,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  // First operand of a sequence: 0 and 1 both collapse to a single beat of 1.
  function automatic logic [WIDTH-1:0] first_operand(input logic [WIDTH-1:0] n);
    first_operand = (n <= WIDTH'(1)) ? WIDTH'(1) : n;
  endfunction

  seq_state_t       state, state_nxt;
  logic             start_fire;
  logic             over_range;
  logic             out_fire;
  logic             load;
  logic             dec;
  logic             q_is_one;
  logic             err_p1;
  logic [WIDTH-1:0] q;

  // An abort cycle suppresses start acceptance even in IDLE.
  assign start_fire = start_valid && start_ready && !abort;
  assign over_range = (start_n > WIDTH'(MAX_N));
  assign out_fire   = out_valid && out_ready;
  assign load       = start_fire && !over_range;
  // The register never steps below 1, so the counter cannot wrap.
  assign dec        = out_fire && !q_is_one && !abort;

  operand_dec_reg #(
    .WIDTH (WIDTH)
  ) u_dec_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (first_operand(start_n)),
    .dec      (dec),
    .q        (q),
    .q_is_one (q_is_one)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Rejection pulse: high for the single cycle after an out-of-range start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= start_fire && over_range;
    end
  end

  // Next-state logic: abort ends a run even if the current beat transfers.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_fire && q_is_one) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from registered state and operand only.
  always_comb begin
    start_ready = (state == IDLE) && !rst;
    busy        = (state == RUN);
    out_valid   = (state == RUN);
    out_last    = (state == RUN) && q_is_one;
    out_data    = q;
    err         = err_p1;
  end

endmodule

// File: tb/tb_fact_operand_seq.sv
// Directed bench for fact_operand_seq: inputs change 1 ns after the rising
// edge and outputs are checked at that same point.
`timescale 1ns/1ps
module tb_fact_operand_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] start_n;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fact_operand_seq #(.WIDTH(W), .MAX_N(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_n     (start_n),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err         (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (start_ready !== 1'b0) begin fails++; $display("FAIL reset_start_ready_in_rst got %b exp 0", start_ready); end
    rst = 1'b0;
    #1;
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_start_ready_after got %b exp 1", start_ready); end
  endtask

  task automatic test_stream_n5();
    out_ready   = 1'b1;
    start_valid = 1'b1;
    start_n     = 32'd5;
    step();
    start_valid = 1'b0;
    tests++; if (start_ready !== 1'b0) begin fails++; $display("FAIL n5_start_ready_busy got %b exp 0", start_ready); end
    for (int k = 5; k >= 1; k--) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL n5_valid beat %0d got %b exp 1", k, out_valid); end
      tests++; if (out_data !== 32'(k)) begin fails++; $display("FAIL n5_data got %0d exp %0d", out_data, k); end
      tests++; if (out_last !== (k == 1)) begin fails++; $display("FAIL n5_last beat %0d got %b exp %b", k, out_last, (k == 1)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL n5_end_valid got %b exp 0", out_valid); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL n5_end_start_ready got %b exp 1", start_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL n5_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int exp_data;
    int beats;
    exp_data = 4;
    beats    = 0;
    out_ready   = 1'b0;
    start_valid = 1'b1;
    start_n     = 32'd4;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid step %0d got %b exp 1", i, out_valid); end
      tests++; if (out_data !== 32'(exp_data)) begin fails++; $display("FAIL bp_data step %0d got %0d exp %0d", i, out_data, exp_data); end
      tests++; if (out_last !== (exp_data == 1)) begin fails++; $display("FAIL bp_last step %0d got %b exp %b", i, out_last, (exp_data == 1)); end
      if (pat[i] && out_valid) beats++;
      step();
      if (pat[i]) exp_data--;
    end
    out_ready = 1'b0;
    tests++; if (beats !== 4) begin fails++; $display("FAIL bp_beats got %0d exp 4", beats); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_end_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_zero_one();
    for (int n = 0; n <= 1; n++) begin
      out_ready   = 1'b0;
      start_valid = 1'b1;
      start_n     = 32'(n);
      step();
      start_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL n%0d_valid got %b exp 1", n, out_valid); end
      tests++; if (out_data !== 32'd1) begin fails++; $display("FAIL n%0d_data got %0d exp 1", n, out_data); end
      tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL n%0d_last got %b exp 1", n, out_last); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL n%0d_end_valid got %b exp 0", n, out_valid); end
      tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL n%0d_end_ready got %b exp 1", n, start_ready); end
    end
  endtask

  task automatic test_range();
    out_ready   = 1'b1;
    start_valid = 1'b1;
    start_n     = 32'd13;
    step();
    start_valid = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL range_err_pulse got %b exp 1", err); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL range_valid got %b exp 0", out_valid); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL range_start_ready got %b exp 1", start_ready); end
    step();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL range_err_clear got %b exp 0", err); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL range_valid_late got %b exp 0", out_valid); end
    // n == MAX_N is the largest accepted request.
    out_ready   = 1'b0;
    start_valid = 1'b1;
    start_n     = 32'd12;
    step();
    start_valid = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL max_err got %b exp 0", err); end
    tests++; if (out_data !== 32'd12 || out_valid !== 1'b1) begin fails++; $display("FAIL max_data got %0d/%b exp 12/1", out_data, out_valid); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL max_abort_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_abort();
    out_ready   = 1'b1;
    start_valid = 1'b1;
    start_n     = 32'd6;
    step();
    start_valid = 1'b0;
    step();
    step();
    tests++; if (out_data !== 32'd4) begin fails++; $display("FAIL abort_pre_data got %0d exp 4", out_data); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL abort_last got %b exp 0", out_last); end
    // A start presented during an IDLE abort cycle is ignored.
    start_valid = 1'b1;
    start_n     = 32'd2;
    abort       = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle_start_busy got %b exp 0", busy); end
    step();
    start_valid = 1'b0;
    tests++; if (out_data !== 32'd2 || out_last !== 1'b0) begin fails++; $display("FAIL abort_n2_first got %0d/%b exp 2/0", out_data, out_last); end
    step();
    tests++; if (out_data !== 32'd1 || out_last !== 1'b1) begin fails++; $display("FAIL abort_n2_second got %0d/%b exp 1/1", out_data, out_last); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_n2_end got %b exp 0", out_valid); end
  endtask

  task automatic test_rst_mid();
    out_ready   = 1'b1;
    start_valid = 1'b1;
    start_n     = 32'd6;
    step();
    start_valid = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    tests++; if (out_data !== 32'd5 || out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_stall got %0d/%b exp 5/1", out_data, out_valid); end
    rst = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL rstmid_data got %0d exp 0", out_data); end
    tests++; if (out_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got last %b busy %b err %b exp 0 0 0", out_last, busy, err); end
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale cycle %0d got %b exp 0", i, out_valid); end
    end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b exp 1", start_ready); end
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    start_n     = '0;
    abort       = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_stream_n5();
    test_backpressure();
    test_zero_one();
    test_range();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
